// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: command, response and APB bus signals of the bridge.
// master modport is the bridge side; slave modport is the driver/slave side.
interface apb_master_bridge_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command to APB requester, one transfer in flight.
// Define APB_MASTER_TIMEOUT_EN to abandon ACCESS after TIMEOUT_CYCLES wait cycles.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 pclk,
    input  logic                 prst_n,
    apb_master_bridge_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } state_e;

    state_e                state_q, state_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES >= 2);
`endif

    // Next state, latched request fields and response capture.
    always_comb begin
        state_d     = state_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    pwrite_d = bus.cmd_write;
                    paddr_d  = bus.cmd_addr;
                    pwdata_d = bus.cmd_wdata;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ACCESS: begin
                if (bus.pready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.pslverr;
                    rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        psel_d    = (state_d == SETUP) || (state_d == ACCESS);
        penable_d = (state_d == ACCESS);
    end

    // State and registered APB/response outputs, cleared asynchronously.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // ACCESS wait-cycle counter for the abandon path.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign bus.cmd_ready = (state_q == IDLE) && prst_n;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: randomized transfers against a transaction-level model.
// Build with APB_MASTER_TIMEOUT_EN to exercise the abandon path (TIMEOUT_CYCLES=4).
module tb_apb_master_bridge;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int TMO = 4;

    logic pclk   = 1'b0;
    logic prst_n = 1'b0;
    int   n_chk  = 0;
    int   n_err  = 0;

    logic [DW-1:0] exp_rdata = '0;
    logic          exp_err   = 1'b0;

    apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master_bridge #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .pclk(pclk),
        .prst_n(prst_n),
        .bus(bus.master)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic junk_slave();
        bus.pready  = 1'b0;
        bus.prdata  = DW'($urandom);
        bus.pslverr = 1'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.cmd_valid = 1'b0;
            junk_slave();
            step();
            chk("idle", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata,
                         bus.psel, bus.penable, bus.cmd_ready},
                {1'b0, exp_err, exp_rdata, 1'b0, 1'b0, 1'b1});
        end
    endtask

    // One transfer: slave answers after 'waits' wait states with rd/err.
    task automatic txn(input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input int waits,
                       input logic [DW-1:0] rd, input logic err);
        int guard = 0;
        while (bus.cmd_ready !== 1'b1 && guard < 10) begin
            step();
            guard++;
        end
        chk("cmd_ready", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = wd;
        junk_slave();
        step();
        bus.cmd_valid = 1'($urandom);
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = AW'($urandom);
        bus.cmd_wdata = DW'($urandom);
        chk("setup", {bus.psel, bus.penable, bus.pwrite, bus.paddr,
                      bus.pwdata, bus.cmd_ready, bus.rsp_valid,
                      bus.rsp_err, bus.rsp_rdata},
            {1'b1, 1'b0, wr, a, wd, 1'b0, 1'b0, exp_err, exp_rdata});
        step();
        for (int i = 0; i <= waits; i++) begin
            chk("access", {bus.psel, bus.penable, bus.pwrite, bus.paddr,
                           bus.pwdata, bus.rsp_valid, bus.cmd_ready},
                {1'b1, 1'b1, wr, a, wd, 1'b0, 1'b0});
            if (i == waits) begin
                bus.pready    = 1'b1;
                bus.prdata    = rd;
                bus.pslverr   = err;
                bus.cmd_valid = 1'b0;
            end else begin
                junk_slave();
            end
            step();
        end
        exp_rdata = wr ? '0 : rd;
        exp_err   = err;
        junk_slave();
        chk("rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata,
                    bus.psel, bus.penable, bus.cmd_ready},
            {1'b1, exp_err, exp_rdata, 1'b0, 1'b0, 1'b1});
    endtask

    task automatic reset_pulse();
        prst_n = 1'b0;
        #1;
        chk("rst_abort", {bus.psel, bus.penable, bus.rsp_valid,
                          bus.rsp_err, bus.rsp_rdata, bus.cmd_ready}, 32'd0);
        step();
        bus.cmd_valid = 1'b0;
        prst_n = 1'b1;
        exp_rdata = '0;
        exp_err   = 1'b0;
        idle(2);
    endtask

    task automatic start_stall(input logic [AW-1:0] a);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = a;
        bus.cmd_wdata = '0;
        junk_slave();
        step();
        bus.cmd_valid = 1'b0;
        step();
    endtask

    initial begin
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 8'h3C;
        bus.cmd_wdata = 8'hFF;
        junk_slave();
        prst_n = 1'b0;
        repeat (3) step();
        chk("reset", {bus.psel, bus.penable, bus.pwrite, bus.paddr,
                      bus.pwdata, bus.rsp_valid, bus.rsp_rdata,
                      bus.rsp_err, bus.cmd_ready}, 32'd0);
        bus.cmd_valid = 1'b0;
        prst_n = 1'b1;
        #1;
        chk("ready_after_rst", 32'(bus.cmd_ready), 32'd1);

        txn(1'b1, 8'h03, 8'hA5, 0, 8'h77, 1'b0);
        idle(1);
        txn(1'b0, 8'h05, 8'h00, 3, 8'h5C, 1'b0);
        txn(1'b0, 8'h09, 8'h11, 0, 8'h42, 1'b1);
        txn(1'b1, 8'h0A, 8'h3E, 1, 8'h99, 1'b0);
        idle(2);

        for (int n = 0; n < 40; n++) begin
            txn(1'($urandom), AW'($urandom), DW'($urandom),
                int'($urandom_range(0, TMO - 1)), DW'($urandom),
                ($urandom_range(0, 3) == 0));
            idle(int'($urandom_range(0, 2)));
        end

        start_stall(8'h21);
        junk_slave();
        step();
        chk("wait_state", {bus.psel, bus.penable, bus.rsp_valid},
            {1'b1, 1'b1, 1'b0});
        reset_pulse();

`ifdef APB_MASTER_TIMEOUT_EN
        start_stall(8'h44);
        for (int i = 0; i < TMO; i++) begin
            chk("tmo_wait", {bus.psel, bus.penable, bus.rsp_valid},
                {1'b1, 1'b1, 1'b0});
            junk_slave();
            step();
        end
        exp_rdata = '0;
        exp_err   = 1'b1;
        chk("tmo_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata,
                        bus.psel, bus.penable, bus.cmd_ready},
            {1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1});
        idle(1);
        txn(1'b0, 8'h45, 8'h00, TMO - 1, 8'hC3, 1'b0);
        idle(1);
`else
        start_stall(8'h44);
        for (int i = 0; i < 22; i++) begin
            chk("no_tmo", {bus.psel, bus.penable, bus.rsp_valid},
                {1'b1, 1'b1, 1'b0});
            junk_slave();
            step();
        end
        reset_pulse();
`endif
        txn(1'b1, 8'h50, 8'h5A, 0, 8'h00, 1'b0);
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB requester (master) that turns a simple valid/ready command interface into APB transfers for the memory-mapped slaves on the same pclk domain.
- Sequences IDLE -> SETUP -> ACCESS, holds ACCESS until pready, and returns read data and slave error on a one-cycle response strobe.
- One transfer in flight at a time. Sits between a local controller or testbench driver and the APB slave bus.

Parameters:
- ADDR_WIDTH, 8, width of cmd_addr and paddr
- DATA_WIDTH, 8, width of write/read data paths
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles waited for pready (used only with the optional feature); must be >= 2

Ports:
- pclk  input  1  APB clock; all logic is rising-edge
- prst_n  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  bridge can accept a command
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_WIDTH  target address
- cmd_wdata  input  DATA_WIDTH  write data
- rsp_valid  output  1  one-cycle pulse: transfer complete
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes
- rsp_err  output  1  pslverr (or timeout) for the completed transfer
- psel  output  1  APB select
- penable  output  1  APB enable
- pwrite  output  1  APB direction
- paddr  output  ADDR_WIDTH  APB address
- pwdata  output  DATA_WIDTH  APB write data
- pready  input  1  slave ready
- prdata  input  DATA_WIDTH  slave read data
- pslverr  input  1  slave error, sampled only with pready in ACCESS

Behaviour:
- Reset (prst_n low, asynchronous):
  - State goes to IDLE.
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err are all 0.
  - cmd_ready is 1 once prst_n is released.
  - Asserting reset mid-transfer aborts it immediately. No response is generated for the aborted transfer.
- All APB and response outputs are registered.
- FSM, 2-bit state, states IDLE=00, SETUP=01, ACCESS=10; code 11 recovers to IDLE.
- IDLE:
  - cmd_ready=1, psel=0, penable=0.
  - On cmd_valid && cmd_ready at edge N: latch cmd_write/addr/wdata into pwrite/paddr/pwdata and go to SETUP.
- SETUP (cycle N+1):
  - psel=1, penable=0, cmd_ready=0.
  - Unconditionally go to ACCESS on the next edge.
- ACCESS:
  - psel=1, penable=1. paddr, pwrite and pwdata are held stable from SETUP through the end of ACCESS.
  - If pready=0, stay in ACCESS (wait states).
  - If pready=1 at an edge:
    - rsp_valid=1 for exactly the next cycle.
    - rsp_err captures pslverr.
    - rsp_rdata captures prdata for reads, 0 for writes.
    - psel and penable drop to 0 and the state returns to IDLE.
- Latency: with a zero-wait slave, command accepted at edge N gives SETUP in N+1, ACCESS in N+2, rsp_valid high in N+3. Each wait state adds one cycle.
- Back-to-back commands: cmd_ready re-asserts in the cycle rsp_valid is high, so the minimum spacing between accepted commands is 3 cycles.
- rsp_rdata and rsp_err hold their values after rsp_valid falls, until the next completion.
- pslverr and prdata are ignored outside ACCESS, and ignored when pready=0.
- cmd_* inputs are ignored while cmd_ready=0. No command buffering.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYCLES with pready still 0, the transfer is abandoned: psel and penable deassert, state returns to IDLE.
  - The abandon completion gives rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - If pready=1 arrives on the same edge the count would reach TIMEOUT_CYCLES, normal completion wins.
- Not defined: no counter logic exists and ACCESS waits for pready indefinitely.

Test Plan:
- Reset: hold prst_n=0 with cmd_valid=1 -> all outputs 0, no APB activity. Release -> cmd_ready=1.
- Zero-wait write: cmd write addr=0x03 data=0xA5 accepted at edge N -> SETUP (psel=1, penable=0, paddr=0x03, pwdata=0xA5) in N+1; ACCESS in N+2; rsp_valid=1, rsp_err=0, rsp_rdata=0x00 in N+3.
- Read with 3 wait states: cmd read addr=0x05; slave drives pready=0 for 3 ACCESS cycles, then pready=1 with prdata=0x5C -> paddr stable throughout, rsp_rdata=0x5C one cycle after pready.
- Slave error: read addr=0x09, slave returns pready=1 with pslverr=1 -> rsp_err=1 for that response. A following good write -> rsp_err=0.
- Reset mid-ACCESS: pulse prst_n low during a wait state -> psel and penable drop immediately, no rsp_valid, FSM in IDLE after release.
- Timeout (with APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4): pready held 0 -> after 4 ACCESS cycles psel falls and rsp_valid=1, rsp_err=1. Without the macro -> psel stays 1 for 20+ cycles.
